// File: rtl/int_ctrl_pkg.sv
// Shared interrupt-controller constants and helpers.
// Also imported by the CPU exception unit.
package int_ctrl_pkg;

  localparam int NUM_CH_DEF      = 4;
  localparam int NEST_DEPTH_DEF  = 4;
  localparam int SYNC_STAGES_DEF = 2;

  // Width needed to hold an index in 0..n-1, never below 1.
  function automatic int ch_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/int_edge_sync.sv
// Multi-flop synchroniser plus rising-edge detector.
// Emits a one-cycle pulse per synchronised rise.
module int_edge_sync
  import int_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic clr_n,
  input  logic raw,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  // Shift the raw line in and keep a delayed copy.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  assign rise = sync[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/nested_int_ctrl.sv
// Nesting interrupt controller: pending latch,
// priority pick, in-service stack, CPU handshake.
module nested_int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int NUM_CH      = NUM_CH_DEF,
  parameter int NEST_DEPTH  = NEST_DEPTH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  localparam int CH_W       = ch_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [NUM_CH-1:0] int_signal,
  input  logic [NUM_CH-1:0] int_mask,
  input  logic              int_enable,
  input  logic              int_ack,
  input  logic              eret,
  output logic              int_req,
  output logic [CH_W-1:0]   int_num,
  output logic [NUM_CH-1:0] int_waiting,
  output logic              in_service,
  output logic [CH_W-1:0]   cur_level,
  output logic              nest_full
);

  localparam int SP_W  = $clog2(NEST_DEPTH + 1);
  localparam int IDX_W = ch_width(NEST_DEPTH);

  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] pend_nx;
  logic [NUM_CH-1:0] elig;
  logic [NUM_CH-1:0] clr_mask;
  logic [CH_W-1:0]   stk [NEST_DEPTH];
  logic [CH_W-1:0]   top_q;
  logic [CH_W-1:0]   top_nx;
  logic [CH_W-1:0]   cand;
  logic [SP_W-1:0]   sp;
  logic [SP_W-1:0]   sp_pop;
  logic [SP_W-1:0]   sp_nx;
  logic [IDX_W-1:0]  push_idx;
  logic [IDX_W-1:0]  top_idx;
  logic              ack_ok;
  logic              pop;
  logic              full_nx;
  logic              preempt;
  logic              req_nx;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_sync
    int_edge_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk  (clk),
      .clr_n(clr_n),
      .raw  (int_signal[g]),
      .rise (rise[g])
    );
  end

  // Next-state stack/pending and the request decision.
  // Pop happens before push so eret+ack swaps the top.
  always_comb begin
    ack_ok   = int_ack & int_req;
    pop      = eret & (sp != '0);
    sp_pop   = sp - SP_W'(pop);
    sp_nx    = sp_pop + SP_W'(ack_ok);
    push_idx = IDX_W'(sp_pop);
    top_idx  = IDX_W'(sp_nx - 1'b1);
    clr_mask = '0;
    if (ack_ok) clr_mask[int_num] = 1'b1;
    pend_nx  = (pending & ~clr_mask) | rise;
    elig     = pend_nx & ~int_mask;
    cand     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (elig[i]) cand = CH_W'(i);
    end
    unique case (1'b1)
      (sp_nx == '0): top_nx = '0;
      ack_ok:        top_nx = int_num;
      default:       top_nx = stk[top_idx];
    endcase
    preempt = (sp_nx == '0) | (cand > top_nx);
    full_nx = (sp_nx == SP_W'(NEST_DEPTH));
    req_nx  = int_enable & (|elig) & preempt
            & ~full_nx;
  end

  // Control state: pending, pointer, top, request.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pending <= '0;
      sp      <= '0;
      top_q   <= '0;
      int_req <= 1'b0;
      int_num <= '0;
    end else begin
      pending <= pend_nx;
      sp      <= sp_nx;
      top_q   <= top_nx;
      int_req <= req_nx;
      int_num <= req_nx ? cand : '0;
    end
  end

  // Stack storage written on each accepted ack.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int i = 0; i < NEST_DEPTH; i++)
        stk[i] <= '0;
    end else if (ack_ok) begin
      stk[push_idx] <= int_num;
    end
  end

  assign int_waiting = pending;
  assign in_service  = (sp != '0);
  assign cur_level   = top_q;
  assign nest_full   = (sp == SP_W'(NEST_DEPTH));

endmodule

// File: tb/tb_nested_int_ctrl.sv
// Bench for nested_int_ctrl: queue-based model,
// per-cycle compare, and directed literal checks.
module tb_nested_int_ctrl;

  localparam int NC = 4;
  localparam int ND = 2;
  localparam int S  = 2;

  logic          clk = 1'b0;
  logic          clr_n = 1'b0;
  logic [NC-1:0] int_signal = '0;
  logic [NC-1:0] int_mask = '0;
  logic          int_enable = 1'b1;
  logic          int_ack = 1'b0;
  logic          eret = 1'b0;
  logic          int_req;
  logic [1:0]    int_num;
  logic [NC-1:0] int_waiting;
  logic          in_service;
  logic [1:0]    cur_level;
  logic          nest_full;

  int total = 0;
  int bad   = 0;

  nested_int_ctrl #(
    .NUM_CH(NC),
    .NEST_DEPTH(ND),
    .SYNC_STAGES(S)
  ) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .int_signal (int_signal),
    .int_mask   (int_mask),
    .int_enable (int_enable),
    .int_ack    (int_ack),
    .eret       (eret),
    .int_req    (int_req),
    .int_num    (int_num),
    .int_waiting(int_waiting),
    .in_service (in_service),
    .cur_level  (cur_level),
    .nest_full  (nest_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h",
               nm, act, exp);
    end
  endtask

  // Model: delay line of samples, pending vector,
  // stack queue of in-service channels.
  logic [NC-1:0] hist [$];
  logic [NC-1:0] m_pend = '0;
  int            m_stk [$];
  bit            m_req = 1'b0;
  int            m_num = 0;

  task m_clear();
    hist = {};
    for (int i = 0; i <= S; i++) hist.push_back('0);
    m_pend = '0;
    m_stk  = {};
    m_req  = 1'b0;
    m_num  = 0;
  endtask

  task m_step();
    logic [NC-1:0] rs;
    logic [NC-1:0] el;
    int            cd;
    bit            ok;
    rs = hist[S-1] & ~hist[S];
    hist.push_front(int_signal);
    void'(hist.pop_back());
    ok = int_ack && m_req;
    if (eret && m_stk.size() > 0)
      void'(m_stk.pop_back());
    if (ok) begin
      m_stk.push_back(m_num);
      m_pend[m_num] = 1'b0;
    end
    m_pend = m_pend | rs;
    el = m_pend & ~int_mask;
    cd = -1;
    for (int i = 0; i < NC; i++)
      if (el[i]) cd = i;
    m_req = int_enable && cd >= 0
         && (m_stk.size() == 0 || cd > m_stk[$])
         && m_stk.size() < ND;
    m_num = m_req ? cd : 0;
  endtask

  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) m_clear();
    else        m_step();
  end

  // Compare every cycle, just after the edge.
  always @(posedge clk) begin
    #1;
    chk("m_req", int_req, m_req);
    chk("m_num", int_num, m_num);
    chk("m_wait", int_waiting, m_pend);
    chk("m_insvc", in_service, m_stk.size() > 0);
    chk("m_level", cur_level,
        m_stk.size() > 0 ? m_stk[$] : 0);
    chk("m_full", nest_full, m_stk.size() == ND);
  end

  task automatic cyc(input logic a, input logic e);
    int_ack = a;
    eret    = e;
    @(posedge clk);
    #1;
    int_ack = 1'b0;
    eret    = 1'b0;
  endtask

  task automatic zeros(input string nm);
    chk({nm, "_req"}, int_req, 0);
    chk({nm, "_num"}, int_num, 0);
    chk({nm, "_wait"}, int_waiting, 0);
    chk({nm, "_insvc"}, in_service, 0);
    chk({nm, "_lvl"}, cur_level, 0);
    chk({nm, "_full"}, nest_full, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    clr_n = 1'b0;
    #1;
    zeros("rst_async");
    int_signal = '0;
    repeat (2) @(posedge clk);
    #1;
    clr_n = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    zeros("rst0");
    clr_n = 1'b1;

    // single channel
    int_signal = 4'b0010;
    cyc(0, 0);
    cyc(0, 0);
    chk("s_wait_e2", int_waiting, 4'b0000);
    cyc(0, 0);
    chk("s_wait_e3", int_waiting, 4'b0010);
    chk("s_req_e3", int_req, 1);
    chk("s_num_e3", int_num, 1);
    int_signal = 4'b0000;
    cyc(1, 0);
    chk("s_wait_ack", int_waiting, 4'b0000);
    chk("s_insvc", in_service, 1);
    chk("s_lvl", cur_level, 1);

    // nesting
    int_signal = 4'b1000;
    repeat (3) cyc(0, 0);
    chk("n_req3", int_req, 1);
    chk("n_num3", int_num, 3);
    cyc(1, 0);
    chk("n_lvl3", cur_level, 3);
    int_signal = 4'b0100;
    repeat (3) cyc(0, 0);
    chk("n_wait2", int_waiting, 4'b0100);
    chk("n_noreq", int_req, 0);
    cyc(0, 1);
    chk("n_eret_lvl", cur_level, 1);
    chk("n_eret_req", int_req, 1);
    chk("n_eret_num", int_num, 2);
    cyc(1, 0);
    chk("n_lvl2", cur_level, 2);
    cyc(0, 1);
    cyc(0, 1);
    chk("n_empty", in_service, 0);

    // mask / enable
    int_signal = 4'b0000;
    int_mask   = 4'b0100;
    cyc(0, 0);
    int_signal = 4'b0100;
    repeat (3) cyc(0, 0);
    chk("m_wait", int_waiting, 4'b0100);
    chk("m_masked", int_req, 0);
    int_mask = 4'b0000;
    cyc(0, 0);
    chk("m_unmask", int_req, 1);
    chk("m_unmask_num", int_num, 2);
    int_enable = 1'b0;
    cyc(0, 0);
    chk("m_disen", int_req, 0);
    chk("m_kept", int_waiting, 4'b0100);
    int_enable = 1'b1;
    cyc(0, 0);
    chk("m_reen", int_req, 1);
    cyc(1, 0);
    chk("m_ack_lvl", cur_level, 2);

    // edge on ch2 during its own ack
    int_signal = 4'b0000;
    cyc(0, 1);
    chk("e_empty", in_service, 0);
    int_signal = 4'b0100;
    cyc(0, 0);
    int_signal = 4'b0000;
    cyc(0, 0);
    int_signal = 4'b0100;
    cyc(0, 0);
    chk("e_req", int_req, 1);
    chk("e_num", int_num, 2);
    cyc(0, 0);
    cyc(1, 0);
    chk("e_wait", int_waiting, 4'b0100);
    chk("e_lvl", cur_level, 2);
    chk("e_noreq", int_req, 0);

    // eret and ack together
    int_signal = 4'b1100;
    repeat (3) cyc(0, 0);
    chk("x_req", int_req, 1);
    chk("x_num", int_num, 3);
    cyc(1, 1);
    chk("x_insvc", in_service, 1);
    chk("x_full", nest_full, 0);
    chk("x_lvl", cur_level, 3);
    chk("x_wait", int_waiting, 4'b0100);

    // full stack
    do_reset();
    int_signal = 4'b0001;
    repeat (3) cyc(0, 0);
    chk("f_num0", int_num, 0);
    chk("f_req0", int_req, 1);
    cyc(1, 0);
    int_signal = 4'b0011;
    repeat (3) cyc(0, 0);
    chk("f_num1", int_num, 1);
    cyc(1, 0);
    chk("f_full", nest_full, 1);
    int_signal = 4'b1011;
    repeat (3) cyc(0, 0);
    chk("f_wait3", int_waiting, 4'b1000);
    chk("f_blocked", int_req, 0);
    cyc(0, 1);
    chk("f_eret_req", int_req, 1);
    chk("f_eret_num", int_num, 3);
    chk("f_eret_lvl", cur_level, 0);
    cyc(1, 0);
    chk("f_full2", nest_full, 1);
    int_signal = 4'b1111;
    repeat (3) cyc(0, 0);
    chk("f_pend2", int_waiting, 4'b0100);

    // reset mid-service, then spurious ack/eret
    do_reset();
    cyc(1, 1);
    zeros("sp1");
    cyc(1, 0);
    cyc(0, 1);
    zeros("sp2");

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule

// File: doc/nested_int_ctrl.md
# nested_int_ctrl

Parametrised, nesting-capable interrupt controller sitting between the external interrupt lines and the CPU's interrupt/ERET logic.
- Synchronises and edge-detects NUM_CH asynchronous request lines, latches them as pending, and applies per-channel masks and a global enable.
- Presents the highest-priority eligible channel to the CPU with a request/acknowledge handshake.
- Tracks in-service channels on a nesting stack, so only strictly higher-priority channels preempt and ERET resumes the interrupted level.

## Interface
Parameters:
- NUM_CH, 4, number of interrupt channels; index NUM_CH-1 has the highest priority.
- NEST_DEPTH, 4, maximum number of simultaneously in-service (nested) channels.
- SYNC_STAGES, 2, synchroniser flops per channel; minimum 2.
- CH_W, derived max(1, clog2(NUM_CH)), channel-number width; not overridable.

Ports:
- clk  in  1  single clock, rising edge.
- clr_n  in  1  reset, asynchronous assert, active-low.
- int_signal  in  NUM_CH  raw asynchronous interrupt lines; a rising edge raises a request.
- int_mask  in  NUM_CH  1 = channel masked (pending kept, not eligible).
- int_enable  in  1  global interrupt enable.
- int_ack  in  1  CPU accepts the current int_req/int_num; single-cycle pulse.
- eret  in  1  return from interrupt; single-cycle pulse.
- int_req  out  1  registered request to the CPU.
- int_num  out  CH_W  channel being requested; 0 when int_req=0.
- int_waiting  out  NUM_CH  pending bits.
- in_service  out  1  nesting stack non-empty.
- cur_level  out  CH_W  channel on top of the stack; 0 when empty.
- nest_full  out  1  stack depth == NEST_DEPTH.

## Operation
- Reset (clr_n=0): all synchroniser/edge flops, pending, stack and stack pointer cleared; every output 0.
- Per channel: SYNC_STAGES-flop synchroniser, then rising-edge detect against a delayed copy. An edge sets pending[i].
- pending[i] clears when an accepted ack grants channel i.
  - If a new edge on channel i occurs in the same cycle as the ack, set wins and pending[i] stays 1.
- eligible = pending & ~int_mask. The candidate is the highest set index of eligible.
- Preemption rule: the candidate may be requested only if the stack is empty or candidate > cur_level. Equal or lower priority waits.
- int_req_next = int_enable & (eligible != 0) & preempt & ~nest_full_next.
  - Computed from next-state pending/stack values, so one channel is never requested twice.
  - int_num is registered alongside int_req.
- int_ack is honoured only when int_req=1; otherwise it is ignored.
  - An accepted ack pushes int_num onto the stack and clears its pending bit.
- eret pops the stack; eret on an empty stack is ignored.
- eret and ack in the same cycle: pop first, then push. Depth stays unchanged and the new top is the acked channel.
- int_req drops on the next edge if its condition vanishes before ack (mask set, enable cleared, channel change). Pending state is retained.
- The stack never exceeds NEST_DEPTH: when full, int_req is held low, so no push can occur.

## Timing
- Edge-to-pending: an int_signal rise meeting setup before edge 1 sets int_waiting at edge SYNC_STAGES+1.
- int_req rises on that same edge if the channel is eligible, with 0 cycles of added latency.
- Ack at edge k: pending cleared, stack pushed and in_service/cur_level updated at edge k. int_req reflects the post-ack state at edge k.
- eret at edge k: the pop is visible at edge k. A waiting lower-priority channel is requested from edge k.
- Reset is asynchronous on assertion. Deassertion is expected synchronous to clk (external reset synchroniser).
- Reset mid-handshake discards pending requests and the whole stack.

## Structure
- Shared package int_ctrl_pkg holds:
  - the clog2-based channel-width function;
  - the default NUM_CH, NEST_DEPTH and SYNC_STAGES constants, shared with the CPU's exception unit.
- Sub-module int_edge_sync is generate-instantiated NUM_CH times. It contains a SYNC_STAGES synchroniser plus the edge detector and emits a one-cycle edge pulse.
- The top level holds the pending register, priority encoder, stack array with pointer, and the registered request logic.

## Test plan
- Single channel: NUM_CH=4, pulse int_signal[1] -> int_waiting=0010 and int_req=1 with int_num=1 at edge 3. Ack -> int_waiting=0000, in_service=1, cur_level=1.
- Nesting: ch1 in service, raise ch3 -> int_req with int_num=3, ack -> cur_level=3. Raise ch2 -> no int_req. eret -> cur_level=1 and int_req with int_num=2 on the same edge.
- Mask/enable: raise ch2 with int_mask[2]=1 -> int_waiting[2]=1, int_req=0. Clear the mask -> int_req next edge. Drop int_enable before ack -> int_req=0 next edge, int_waiting[2] still 1.
- Full stack: NEST_DEPTH=2, ack ch0 then ch1 -> nest_full=1. Raise ch3 -> int_req stays 0. eret -> int_req=1, int_num=3.
- Simultaneous events: eret and ack in one cycle -> depth unchanged, cur_level = acked channel. Edge on ch2 during its own ack -> int_waiting[2] stays 1.
- Reset: assert clr_n=0 mid-service with 2 stacked and 1 pending -> all outputs 0 immediately. Spurious ack/eret after reset -> no state change.
